uart_rx_ctrl: RTL and testbench

Controller that sequences and services the 8N1 UART receiver. Generates the receiver's x16-oversample `tick` from the system clock via a programmable divisor. Holds the receiver in reset while disabled and detects each completed byte on its `done` output. Buffers received bytes in a small first-word-fall-through FIFO with a valid/ready read port and a sticky overrun flag.

---
 rtl/uart_rx_ctrl_if.sv | 10 +
 rtl/uart_rx_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready read port of the uart_rx_ctrl receive FIFO.
// The controller is the master (drives data/valid), the consumer is the slave.
interface uart_rx_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences an 8N1 UART receiver. It generates the x16
// oversample tick, holds the receiver in reset while disabled, detects
// completed bytes on the receiver's done level and buffers them in a small
// first-word-fall-through FIFO with a sticky overrun flag.
module uart_rx_ctrl #(
    parameter int DIV_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DIV_WIDTH-1:0]   divisor,
    output logic                   tick,
    output logic                   rx_reset,
    input  logic                   rx_done,
    input  logic [7:0]             rx_data,
    uart_rx_ctrl_if.master         out_bus,
    output logic                   overrun,
    input  logic                   clear_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 wake_cnt;
    logic                 wake_cnt_next;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 done_q;
    logic                 armed;
    logic                 push_req;

    logic [7:0]           mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_next;
    logic [7:0]           head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 do_pop;
    logic                 do_push;
    logic                 drop;

    // Next-state logic: OFF -> WAKE (two cycles) -> RUN; disable always returns to OFF.
    always_comb begin
        state_next    = state;
        wake_cnt_next = 1'b0;
        case (state)
            ST_OFF: begin
                if (enable) begin
                    state_next = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_cnt) begin
                    state_next = ST_RUN;
                end else begin
                    wake_cnt_next = 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
        if (!enable) begin
            state_next    = ST_OFF;
            wake_cnt_next = 1'b0;
        end
    end

    // State register; rx_reset is registered from the next state so it never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_OFF;
            wake_cnt <= 1'b0;
            rx_reset <= 1'b0;
        end else begin
            state    <= state_next;
            wake_cnt <= wake_cnt_next;
            rx_reset <= (state_next == ST_RUN);
        end
    end

    // Tick divider: >= compare so a lowered divisor reloads immediately instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (enable && rx_reset) begin
            if (div_cnt >= divisor) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
                tick    <= 1'b0;
            end
        end else begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end
    end

    // Done edge detect; arming waits for done to drop because the receiver wakes with done high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            done_q <= rx_done;
            armed  <= rx_reset ? (armed | ~rx_done) : 1'b0;
        end
    end

    // FIFO control decode: a push while full only survives if the head leaves in the same cycle.
    always_comb begin
        push_req   = armed & rx_reset & rx_done & ~done_q;
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(DEPTH));
        do_pop     = ~fifo_empty & out_bus.out_ready;
        do_push    = push_req & (~fifo_full | do_pop);
        drop       = push_req & fifo_full & ~do_pop;
        rd_next    = rd_ptr + PTR_W'(1);
    end

    // Storage array has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers, occupancy, registered head byte and sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            head    <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (do_push && (fifo_empty || (do_pop && count == CNT_W'(1)))) begin
                head <= rx_data;
            end else if (do_pop && count != CNT_W'(1)) begin
                head <= mem[rd_next];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign out_bus.out_data  = head;
    assign out_bus.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed sequencing/divider checks plus a
// queue-based FIFO reference model feeding a scoreboard that a separate
// monitor drains whenever the DUT hands over a byte.
module tb_uart_rx_ctrl;
    localparam int DIV_WIDTH = 16;
    localparam int DEPTH     = 4;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 enable    = 1'b0;
    logic [DIV_WIDTH-1:0] divisor   = 16'd3;
    logic                 tick;
    logic                 rx_reset;
    logic                 rx_done   = 1'b1;
    logic [7:0]           rx_data   = 8'h00;
    logic                 overrun;
    logic                 clear_err = 1'b0;
    logic [2:0]           count;

    uart_rx_ctrl_if out_bus();

    int         checks       = 0;
    int         errors       = 0;
    int         model_count  = 0;
    bit         model_ovr    = 1'b0;
    logic [7:0] exp_q[$];
    bit         pending_push = 1'b0;
    int         ready_mode   = 0;

    uart_rx_ctrl #(
        .DIV_WIDTH(DIV_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .divisor(divisor),
        .tick(tick),
        .rx_reset(rx_reset),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .out_bus(out_bus),
        .overrun(overrun),
        .clear_err(clear_err),
        .count(count)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and refresh per-cycle inputs.
    task automatic step_cycle();
        @(negedge clk);
        pending_push = 1'b0;
        clear_err    = 1'b0;
        if (ready_mode == 1) begin
            out_bus.out_ready = ~out_bus.out_ready;
        end else if (ready_mode == 2) begin
            out_bus.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Emulate one received byte: done drops, then rises with the byte on it.
    task automatic applyStimulus(input logic [7:0] data, input int low_cycles, input bit with_clear,
                                 input bit force_ready, input bit ready_val);
        step_cycle();
        rx_done = 1'b0;
        for (int i = 1; i < low_cycles; i++) begin
            step_cycle();
        end
        step_cycle();
        rx_done      = 1'b1;
        rx_data      = data;
        pending_push = 1'b1;
        clear_err    = with_clear;
        if (force_ready) begin
            out_bus.out_ready = ready_val;
        end
        step_cycle();
    endtask

    task automatic expect_tick_after(input string name, input int cycles);
        int seen_at;
        seen_at = 0;
        for (int i = 1; i <= 64; i++) begin
            step_cycle();
            if (tick === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        checkOutput(name, seen_at, cycles);
    endtask

    task automatic enable_and_check_wake(input string name);
        step_cycle();
        enable = 1'b1;
        step_cycle();
        checkOutput({name, "_wake1_rx_reset"}, rx_reset, 0);
        step_cycle();
        checkOutput({name, "_wake2_rx_reset"}, rx_reset, 0);
        checkOutput({name, "_wake2_tick"}, tick, 0);
        step_cycle();
        checkOutput({name, "_run_rx_reset"}, rx_reset, 1);
    endtask

    task automatic drain_fifo(input string name);
        int n;
        n = 0;
        ready_mode = 0;
        out_bus.out_ready = 1'b1;
        while (model_count != 0 && n < 50) begin
            step_cycle();
            n++;
        end
        checkOutput(name, count, 0);
        out_bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, "_tick"}, tick, 0);
        checkOutput({name, "_rx_reset"}, rx_reset, 0);
        checkOutput({name, "_out_valid"}, out_bus.out_valid, 0);
        checkOutput({name, "_out_data"}, out_bus.out_data, 0);
        checkOutput({name, "_overrun"}, overrun, 0);
        checkOutput({name, "_count"}, count, 0);
    endtask

    // Reference model: FIFO occupancy and overrun from the push/pop rules; accepted bytes go to the scoreboard.
    initial begin : ref_model
        bit pop_now;
        bit drop_now;
        forever begin
            @(posedge clk);
            if (!reset) begin
                model_count = 0;
                model_ovr   = 1'b0;
            end else begin
                pop_now  = (model_count != 0) && (out_bus.out_ready == 1'b1);
                drop_now = pending_push && (model_count == DEPTH) && !pop_now;
                if (pending_push && !drop_now) begin
                    exp_q.push_back(rx_data);
                    model_count++;
                end
                if (pop_now) begin
                    model_count--;
                end
                if (drop_now) begin
                    model_ovr = 1'b1;
                end else if (clear_err) begin
                    model_ovr = 1'b0;
                end
            end
        end
    end

    // Monitor: just before each rising edge compare occupancy/flags and check every handed-over byte.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                exp_q.delete();
                continue;
            end
            checkOutput("mon_count", count, model_count);
            checkOutput("mon_overrun", overrun, model_ovr);
            checkOutput("mon_out_valid", out_bus.out_valid, (model_count != 0));
            if (out_bus.out_valid === 1'b1 && out_bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_data: got 0x%0h, expected no byte", out_bus.out_data);
                end else begin
                    checkOutput("pop_data", out_bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Bound the whole run.
    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int quiet;
        out_bus.out_ready = 1'b0;
        $display("[TB] reset state");
        repeat (3) step_cycle();
        check_reset_values("reset");
        reset = 1'b1;
        repeat (3) step_cycle();
        checkOutput("off_rx_reset", rx_reset, 0);
        checkOutput("off_tick", tick, 0);

        $display("[TB] wake sequencing and divider");
        enable_and_check_wake("first");
        expect_tick_after("first_tick", 4);
        expect_tick_after("tick_period_a", 4);
        expect_tick_after("tick_period_b", 4);
        step_cycle();
        step_cycle();
        divisor = 16'd1;
        expect_tick_after("div_lowered_tick", 1);
        expect_tick_after("div_lowered_period", 2);
        divisor = 16'd0;
        expect_tick_after("div_zero_a", 1);
        expect_tick_after("div_zero_b", 1);
        checkOutput("no_push_unarmed", count, 0);

        $display("[TB] arming");
        applyStimulus(8'hA5, 1, 1'b0, 1'b0, 1'b0);
        checkOutput("arm_count", count, 1);
        checkOutput("arm_head", out_bus.out_data, 8'hA5);
        step_cycle();
        out_bus.out_ready = 1'b1;
        step_cycle();
        out_bus.out_ready = 1'b0;

        $display("[TB] ordering and wrap");
        ready_mode = 1;
        for (int v = 1; v <= 6; v++) begin
            applyStimulus(8'(v), 1 + int'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        drain_fifo("order_drained");
        checkOutput("order_no_overrun", overrun, 0);

        $display("[TB] overrun");
        out_bus.out_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(8'h10 + 8'(v), 1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("ovr_count", count, 4);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_head", out_bus.out_data, 8'h10);
        applyStimulus(8'h15, 1, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_set_beats_clear", overrun, 1);
        checkOutput("ovr_count_kept", count, 4);
        step_cycle();
        clear_err = 1'b1;
        step_cycle();
        checkOutput("ovr_cleared", overrun, 0);

        $display("[TB] full with simultaneous push and pop");
        applyStimulus(8'h77, 1, 1'b0, 1'b1, 1'b1);
        out_bus.out_ready = 1'b0;
        checkOutput("full_pushpop_count", count, 4);
        checkOutput("full_pushpop_no_ovr", overrun, 0);
        checkOutput("full_pushpop_head", out_bus.out_data, 8'h11);
        drain_fifo("full_drained");
        checkOutput("empty_holds_last", out_bus.out_data, 8'h77);

        $display("[TB] randomized traffic");
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                divisor = 16'($urandom_range(0, 7));
            end
            applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0);
        end
        drain_fifo("random_drained");
        step_cycle();
        clear_err = 1'b1;
        step_cycle();
        checkOutput("random_ovr_cleared", overrun, 0);

        $display("[TB] disable mid-byte");
        divisor = 16'd2;
        applyStimulus(8'h3C, 1, 1'b0, 1'b0, 1'b0);
        step_cycle();
        rx_done = 1'b0;
        step_cycle();
        step_cycle();
        enable = 1'b0;
        step_cycle();
        checkOutput("dis_rx_reset", rx_reset, 0);
        checkOutput("dis_tick", tick, 0);
        checkOutput("dis_count", count, 1);
        checkOutput("dis_head", out_bus.out_data, 8'h3C);
        rx_done = 1'b1;
        quiet = 0;
        repeat (6) begin
            step_cycle();
            quiet += int'(tick);
        end
        checkOutput("off_tick_quiet", quiet, 0);
        checkOutput("off_no_push", count, 1);
        enable_and_check_wake("reenable");
        applyStimulus(8'h5A, 2, 1'b0, 1'b0, 1'b0);
        checkOutput("reenable_push", count, 2);
        drain_fifo("reenable_drained");

        $display("[TB] asynchronous reset with data buffered");
        out_bus.out_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(8'hC0 + 8'(v), 1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("pre_reset_overrun", overrun, 1);
        checkOutput("pre_reset_count", count, 4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) step_cycle();
        reset = 1'b1;
        repeat (4) step_cycle();
        checkOutput("post_reset_count", count, 0);
        checkOutput("post_reset_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
